draw_background_gen: RTL and testbench

Parametrised next-generation background renderer for the VGA pixel pipeline. It sits directly after the timing generator and ahead of the overlay/sprite stages. It forwards all timing signals through a configurable-depth register pipeline and generates a 12-bit RGB background. There are four selectable patterns; mode, fill colour and animation state are updated only at frame boundaries, so the picture never tears mid-frame.

---
 rtl/draw_background_gen_if.sv | 32 +++
 rtl/draw_background_gen.sv | 136 +++++++++++++
 tb/tb_draw_background_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_background_gen_if.sv
// rtl/draw_background_gen_if.sv - VGA timing bus into and out of the background renderer
//
// Carries the raw timing from the timing generator (*_in) and the delayed
// timing plus background colour towards the overlay stages (*_out).
//   master : timing generator side, drives *_in, observes *_out
//   slave  : renderer side, consumes *_in, drives *_out
interface draw_background_gen_if;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        hblnk_in;
    logic        vsync_in;
    logic        vblnk_in;

    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
        input  hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
        output hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out
    );
endinterface

// File: rtl/draw_background_gen.sv
// rtl/draw_background_gen.sv - background pattern renderer with delayed VGA timing
//
// Forwards the timing bus through a LATENCY-deep register pipeline and
// produces a 12-bit background colour aligned with it. Pattern mode, fill
// colour and the frame counter change only on the rising edge of vblnk, so a
// frame is always drawn with one consistent setting.
// Ports:
//   pclk          pixel clock
//   rst_n         asynchronous active-low reset
//   mode_in       pattern select (0 fill, 1 checker, 2 bars, 3 gradient)
//   fill_rgb_in   fill colour for modes 0 and 1
//   frame_cnt_out running frame counter (undelayed)
//   vga           timing bus, *_in from the timing generator, *_out delayed
module draw_background_gen #(
    parameter int H_ACTIVE  = 800,
    parameter int V_ACTIVE  = 600,
    parameter int LATENCY   = 1,
    parameter bit BORDER_EN = 1'b1,
    parameter int TILE_LOG2 = 5,
    parameter int BAR_LOG2  = 7
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [1:0]  mode_in,
    input  logic [11:0] fill_rgb_in,
    output logic [7:0]  frame_cnt_out,
    draw_background_gen_if.slave vga
);

    localparam int          STAGE_W = 11 + 11 + 4 + 12;
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [10:0] V_LAST  = 11'(V_ACTIVE - 1);

    logic [1:0]  mode_q, mode_d;
    logic [11:0] fill_q, fill_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        vblnk_prev_q;
    logic        frame_evt;

    logic        tile_odd;
    logic [10:0] bar_idx;
    logic [2:0]  bar;
    logic [7:0]  grad_sum;
    logic        unused_grad_lo;
    logic [11:0] rgb_d;

    logic [STAGE_W-1:0] stage_d;
    logic [STAGE_W-1:0] pipe_q [LATENCY];

    assign frame_evt = vga.vblnk_in & ~vblnk_prev_q;

    // Frame-boundary state: latched only on the vblnk rising edge.
    always_comb begin
        mode_d      = mode_q;
        fill_d      = fill_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_evt) begin
            mode_d      = mode_in;
            fill_d      = fill_rgb_in;
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // vblnk_prev resets high so releasing reset inside vblank is not mistaken
    // for the start of a new frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= 2'd0;
            fill_q       <= 12'h888;
            frame_cnt_q  <= 8'd0;
            vblnk_prev_q <= 1'b1;
        end else begin
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            frame_cnt_q  <= frame_cnt_d;
            vblnk_prev_q <= vga.vblnk_in;
        end
    end

    // Only bit 0 of the tile-index xor matters, which is the xor of the two
    // coordinate bits at the tile-size position.
    assign tile_odd = vga.hcount_in[TILE_LOG2] ^ vga.vcount_in[TILE_LOG2];
    assign bar_idx  = vga.hcount_in >> BAR_LOG2;
    assign bar      = (bar_idx > 11'd7) ? 3'd7 : bar_idx[2:0];

    // Bits [7:4] of the 11-bit sum depend only on the low byte of each operand.
    assign grad_sum       = vga.hcount_in[7:0] + frame_cnt_q;
    assign unused_grad_lo = ^grad_sum[3:0];

    always_comb begin
        rgb_d = 12'h000;
        if (vga.hblnk_in || vga.vblnk_in) begin
            rgb_d = 12'h000;
        end else if (BORDER_EN && (vga.vcount_in == 11'd0)) begin
            rgb_d = 12'hff0;
        end else if (BORDER_EN && (vga.vcount_in == V_LAST)) begin
            rgb_d = 12'hf00;
        end else if (BORDER_EN && (vga.hcount_in == 11'd0)) begin
            rgb_d = 12'h0f0;
        end else if (BORDER_EN && (vga.hcount_in == H_LAST)) begin
            rgb_d = 12'h00f;
        end else begin
            case (mode_q)
                2'd0:    rgb_d = fill_q;
                2'd1:    rgb_d = tile_odd ? (fill_q ^ 12'hfff) : fill_q;
                2'd2:    rgb_d = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
                default: rgb_d = {grad_sum[7:4], vga.vcount_in[7:4], frame_cnt_q[7:4]};
            endcase
        end
    end

    assign stage_d = {vga.hcount_in, vga.vcount_in,
                      vga.hsync_in, vga.hblnk_in, vga.vsync_in, vga.vblnk_in,
                      rgb_d};

    // Timing and colour travel in one word so they stay aligned at any depth.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign {vga.hcount_out, vga.vcount_out,
            vga.hsync_out, vga.hblnk_out, vga.vsync_out, vga.vblnk_out,
            vga.rgb_out} = pipe_q[LATENCY-1];

    assign frame_cnt_out = frame_cnt_q;

endmodule

// File: tb/tb_draw_background_gen.sv
// tb/tb_draw_background_gen.sv - scoreboard bench for draw_background_gen at LATENCY 1 and 4
module tb_draw_background_gen;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  mode_in = 2'd0;
    logic [11:0] fill_rgb_in = 12'h888;
    logic [10:0] h_drv = '0;
    logic [10:0] v_drv = '0;
    logic        hs_drv = 1'b0;
    logic        hb_drv = 1'b0;
    logic        vs_drv = 1'b0;
    logic        vb_drv = 1'b1;
    logic [7:0]  fc1, fc4;

    always #5 pclk = ~pclk;

    draw_background_gen_if vga1 ();
    draw_background_gen_if vga4 ();

    assign vga1.hcount_in = h_drv;
    assign vga1.vcount_in = v_drv;
    assign vga1.hsync_in  = hs_drv;
    assign vga1.hblnk_in  = hb_drv;
    assign vga1.vsync_in  = vs_drv;
    assign vga1.vblnk_in  = vb_drv;
    assign vga4.hcount_in = h_drv;
    assign vga4.vcount_in = v_drv;
    assign vga4.hsync_in  = hs_drv;
    assign vga4.hblnk_in  = hb_drv;
    assign vga4.vsync_in  = vs_drv;
    assign vga4.vblnk_in  = vb_drv;

    draw_background_gen #(.LATENCY(1)) dut1 (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .mode_in       (mode_in),
        .fill_rgb_in   (fill_rgb_in),
        .frame_cnt_out (fc1),
        .vga           (vga1)
    );

    draw_background_gen #(.LATENCY(4)) dut4 (
        .pclk          (pclk),
        .rst_n         (rst_n),
        .mode_in       (mode_in),
        .fill_rgb_in   (fill_rgb_in),
        .frame_cnt_out (fc4),
        .vga           (vga4)
    );

    logic [37:0] out1, out4;
    assign out1 = {vga1.hcount_out, vga1.vcount_out, vga1.hsync_out, vga1.hblnk_out,
                   vga1.vsync_out, vga1.vblnk_out, vga1.rgb_out};
    assign out4 = {vga4.hcount_out, vga4.vcount_out, vga4.hsync_out, vga4.hblnk_out,
                   vga4.vsync_out, vga4.vblnk_out, vga4.rgb_out};

    typedef struct packed {
        logic [63:0] tag;
        int          due;
        logic [37:0] exp;
    } sb_item_t;

    sb_item_t q1[$];
    sb_item_t q4[$];

    int edges = 0;
    always @(posedge pclk) edges <= edges + 1;

    int n_pass = 0;
    int n_chk  = 0;

    logic [1:0]  m_mode;
    logic [11:0] m_fill;
    int          m_fc;
    bit          m_vprev;
    bit          hs1_seen, hs4_seen;

    task automatic check_val(input string tag, input logic [37:0] obs, input logic [37:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_mode  = 2'd0;
        m_fill  = 12'h888;
        m_fc    = 0;
        m_vprev = 1'b1;
    endtask

    function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb);
        int b, s;
        if (hb || vb) return 12'h000;
        if (v == 0)   return 12'hff0;
        if (v == 599) return 12'hf00;
        if (h == 0)   return 12'h0f0;
        if (h == 799) return 12'h00f;
        case (m_mode)
            2'd0: return m_fill;
            2'd1: return ((((h / 32) + (v / 32)) % 2) == 1) ? ~m_fill : m_fill;
            2'd2: begin
                b = h / 128;
                if (b > 7) b = 7;
                return {((b & 4) != 0) ? 4'hf : 4'h0,
                        ((b & 2) != 0) ? 4'hf : 4'h0,
                        ((b & 1) != 0) ? 4'hf : 4'h0};
            end
            default: begin
                s = (h + m_fc) % 2048;
                return {4'((s / 16) % 16), 4'((v / 16) % 16), 4'(m_fc / 16)};
            end
        endcase
    endfunction

    task automatic check_outputs();
        sb_item_t it;
        if (q1.size() > 0 && q1[0].due == edges) begin
            it = q1.pop_front();
            check_val($sformatf("%s_L1", it.tag), out1, it.exp);
        end else begin
            check_val("idle_L1", out1, '0);
        end
        if (q4.size() > 0 && q4[0].due == edges) begin
            it = q4.pop_front();
            check_val($sformatf("%s_L4", it.tag), out4, it.exp);
        end else begin
            check_val("idle_L4", out4, '0);
        end
        check_val("fcnt_L1", {30'd0, fc1}, 38'(m_fc));
        check_val("fcnt_L4", {30'd0, fc4}, 38'(m_fc));
        hs1_seen = vga1.hsync_out;
        hs4_seen = vga4.hsync_out;
    endtask

    // Called at a falling edge: drive one pixel, record expectations, run one cycle.
    task automatic tick(input int h, input int v, input bit hs, input bit hb,
                        input bit vs, input bit vb, input logic [63:0] tag,
                        input bit use_c, input logic [11:0] c_rgb);
        sb_item_t it;
        logic [11:0] e;
        h_drv  = 11'(h);
        v_drv  = 11'(v);
        hs_drv = hs;
        hb_drv = hb;
        vs_drv = vs;
        vb_drv = vb;
        e = use_c ? c_rgb : model_rgb(h, v, hb, vb);
        it.tag = tag;
        it.exp = {11'(h), 11'(v), hs, hb, vs, vb, e};
        it.due = edges + 1;
        q1.push_back(it);
        it.due = edges + 4;
        q4.push_back(it);
        if (vb && !m_vprev) begin
            m_mode = mode_in;
            m_fill = fill_rgb_in;
            m_fc   = (m_fc + 1) % 256;
        end
        m_vprev = vb;
        @(posedge pclk);
        @(negedge pclk);
        check_outputs();
    endtask

    task automatic px(input int h, input int v);
        tick(h, v, 1'b0, 1'b0, 1'b0, 1'b0, "px", 1'b0, 12'h000);
    endtask

    task automatic named(input int h, input int v, input logic [63:0] tag, input logic [11:0] c);
        tick(h, v, 1'b0, 1'b0, 1'b0, 1'b0, tag, 1'b1, c);
    endtask

    task automatic frame_evt();
        tick(0, 600, 1'b0, 1'b0, 1'b0, 1'b1, "vbl", 1'b0, 12'h000);
        tick(5, 601, 1'b0, 1'b0, 1'b1, 1'b1, "vbl", 1'b0, 12'h000);
        px(200, 100);
    endtask

    int first1, first4, highs4;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check_val("rst_out_L1", out1, '0);
        check_val("rst_out_L4", out4, '0);
        check_val("rst_fcnt", {30'd0, fc1}, '0);
        rst_n = 1'b1;

        // Mode 0 with default fill, borders and blanking
        named(0, 0, "brd_top", 12'hff0);
        named(799, 300, "brd_rt", 12'h00f);
        named(400, 300, "m0_fill", 12'h888);
        named(0, 300, "brd_lf", 12'h0f0);
        named(10, 599, "brd_bot", 12'hf00);
        tick(100, 300, 1'b0, 1'b1, 1'b0, 1'b0, "hblnk", 1'b1, 12'h000);
        px(401, 300);

        // Mode switch mid-frame takes effect only after vblnk rises
        mode_in = 2'd2;
        named(300, 10, "sw_keep", 12'h888);
        frame_evt();
        named(300, 10, "bar2", 12'h0f0);
        named(799, 10, "bar_brd", 12'h00f);
        named(1100, 10, "bar_clmp", 12'hfff);
        px(700, 20);

        // Checkerboard
        mode_in = 2'd1;
        fill_rgb_in = 12'h123;
        frame_evt();
        named(40, 10, "chk_edc", 12'hedc);
        named(70, 10, "chk_123", 12'h123);
        px(33, 33);

        // Gradient at frame_cnt = 20
        mode_in = 2'd3;
        repeat (18) frame_evt();
        check_val("fc20", {30'd0, fc1}, 38'd20);
        named(100, 48, "grad", 12'h731);
        px(790, 500);

        // Frame counter wrap
        repeat (236) frame_evt();
        check_val("wrap", {30'd0, fc1}, 38'd0);

        // Single-cycle hsync pulse latency
        first1 = -1;
        first4 = -1;
        highs4 = 0;
        for (int i = 0; i < 7; i++) begin
            tick(400, 300, (i == 0), 1'b0, 1'b0, 1'b0, "hs", 1'b0, 12'h000);
            if (hs1_seen && first1 < 0) first1 = i;
            if (hs4_seen) begin
                highs4++;
                if (first4 < 0) first4 = i;
            end
        end
        check_val("hs1_edges", 38'(first1 + 1), 38'd1);
        check_val("hs4_edges", 38'(first4 + 1), 38'd4);
        check_val("hs4_width", 38'(highs4), 38'd1);

        // Asynchronous reset mid-line, released inside vblank
        repeat (5) px(300, 200);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_L1", out1, '0);
        check_val("arst_L4", out4, '0);
        check_val("arst_fcnt", {30'd0, fc1}, '0);
        q1.delete();
        q4.delete();
        model_reset();
        vb_drv = 1'b1;
        @(negedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (3) tick(0, 600, 1'b0, 1'b0, 1'b0, 1'b1, "vbl", 1'b0, 12'h000);
        check_val("no_spur", {30'd0, fc1}, 38'd0);
        named(400, 300, "rst_fill", 12'h888);
        frame_evt();
        check_val("post_rise", {30'd0, fc1}, 38'd1);
        repeat (4) px(400, 300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
